sap_controller: RTL and testbench
=================================

# sap_controller

Controller/sequencer for the 8-bit bus computer: a six-state ring counter (T1–T6) that decodes the 4-bit opcode from the instruction register and drives the packed control word. The control word sets which module drives the bus and which modules load from it: program counter, MAR, RAM, IR, accumulator, B register, ALU and output register. The controller replaces the manual `sel`/`go` programming path during program execution and owns the halt state.

## Interface
- No parameters; widths, opcodes and control-bit positions are package constants.
- `CLK  in  1`: single system clock; all state changes on its rising edge.
- `RESET  in  1`: asynchronous, active-high; forces T1, clears the halt state, clears the latched opcode and zeroes the control word.
- `run  in  1`: step enable. High: the sequencer advances each cycle. Low: the state is frozen and `ctrl` is forced to 0.
- `halt_req  in  1`: external halt request; sticky until it is honoured.
- `opcode  in  4`: IR upper nibble; valid from T4 onward.
- `ctrl  out  13`: control word. Bit map: 0 Cp, 1 Ep, 2 Lm, 3 CE, 4 Li, 5 Ei, 6 La, 7 Ea, 8 Su, 9 Eu, 10 Lb, 11 Lo, 12 Lp.
- `t_state  out  6`: one-hot ring state, bit0 = T1. Reset value 6'b000001.
- `instr_done  out  1`: high during T6 when `run` is high. Reset value 0.
- `halted  out  1`: high in HALTED. Reset value 0.

## Operation
- **States:** T1…T6 and HALTED. T6 → T1 at each advance. HALTED is absorbing; only RESET exits it.
- **Decode:** `ctrl` is a combinational decode of the state register and the opcode, gated by `run`. Modules act on the rising edge that ends the state.
- **Fetch (all opcodes):** T1 Ep|Lm; T2 Cp; T3 CE|Li.
- **Opcode latch:** `opcode` is latched into `op_q` on the T4→T5 edge. T5 and T6 decode from `op_q`; T4 decodes the live `opcode`.
- **LDA 0000:** T4 Ei|Lm; T5 CE|La; T6 none.
- **ADD 0001:** T4 Ei|Lm; T5 CE|Lb; T6 Eu|La.
- **SUB 0010:** same as ADD, plus Su in T6.
- **OUT 1110:** T4 Ea|Lo; T5 none; T6 none.
- **HLT 1111:** T4 `ctrl` = 0; the next advancing edge goes to HALTED instead of T5.
- **Undefined opcodes:** NOP, six cycles with an empty T4–T6.
- **halt_req:** latched into `halt_pend`. When `halt_pend` is set, the T6 advance goes to HALTED instead of T1, so the current instruction always completes. A request arriving in T6 is honoured on that same edge.
- **HALTED:** `ctrl` = 0, `t_state` = 0, `halted` = 1.
- **Control-word invariants:** at most one bus driver (Ep, CE, Ei, Ea, Eu) is asserted per state. Lp stays 0 unless the configuration macro is defined.

## Timing
- Each instruction takes exactly 6 advancing cycles. HLT takes 4 cycles and then stays in HALTED.
- **run low:** no advance and `ctrl` = 0, so no load or increment is ever repeated. Raising `run` resumes in the same state with its full control word.
- **RESET:** asynchronous at any point, including mid-instruction and in HALTED. Outputs take their reset values immediately; the first T1 after release is a clean fetch.
- **halt_req with run low:** still latched; it takes effect at the next advancing T6 edge.

## Configuration
- **`SAP_CNTRL_JMP_EN` defined:** opcode 0011 is JMP: T4 Ei|Lp (PC loads the operand nibble), T5 none, T6 none.
- **`SAP_CNTRL_JMP_EN` not defined:** 0011 is an undefined opcode (NOP), and `ctrl[12]` is tied to 0.

## Structure
- **Package `sap_pkg`:** opcode constants; control-bit index constants; the `ctrl_t` packed type (13 bits); the `tstate_e` enum (T1–T6, HALTED).
- **Sub-module `sap_ring_counter`:** state register with run gating, halt entry and the one-hot `t_state` output. Decode stays in `sap_controller`.

## Test plan
- **LDA (0000), run high:** `ctrl` in T1..T6 = 0x006, 0x001, 0x018, 0x024, 0x048, 0x000; `instr_done` high only in T6.
- **ADD then SUB:** ADD T5 = 0x408, ADD T6 = 0x240; SUB T6 = 0x340. OUT (1110) T4 = 0x880.
- **run low in T2 for 3 cycles:** `ctrl` = 0 and `t_state` = 6'b000010 throughout; on resume, Cp is high for exactly one cycle.
- **HLT (1111):** after T4, `halted` = 1, `t_state` = 0, `ctrl` = 0 for 20 cycles. RESET then gives `t_state` = 6'b000001 with `ctrl` = 0x006.
- **halt_req pulsed in ADD T3:** T4–T6 complete (T6 = 0x240), then HALTED with no fetch. RESET asserted mid-T5 zeroes `ctrl` immediately, with no clock edge needed.
- **JMP (0011):** with `SAP_CNTRL_JMP_EN`, T4 = 0x1020; without it, T4 = 0x000.

Source files
------------

// File: rtl/sap_pkg.sv
// sap_pkg: opcodes, control-word bit positions and shared types for the SAP controller.
// Opcode 0011 is JMP only when SAP_CNTRL_JMP_EN is defined.
package sap_pkg;
    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_JMP = 4'b0011;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;
    localparam int CP = 0;
    localparam int EP = 1;
    localparam int LM = 2;
    localparam int CE = 3;
    localparam int LI = 4;
    localparam int EI = 5;
    localparam int LA = 6;
    localparam int EA = 7;
    localparam int SU = 8;
    localparam int EU = 9;
    localparam int LB = 10;
    localparam int LO = 11;
    localparam int LP = 12;
    localparam int CTRL_W = 13;
    typedef logic [CTRL_W-1:0] ctrl_t;
    typedef enum logic [2:0] {T1, T2, T3, T4, T5, T6, HALTED} tstate_e;
    function automatic ctrl_t cw(input int unsigned b);
        return ctrl_t'(1) << b;
    endfunction
endpackage

// File: rtl/sap_ring_counter.sv
// sap_ring_counter: T1..T6 ring with run gating, halt entry (HLT at T4 or pending halt at T6)
// and the one-hot t_state view.
module sap_ring_counter
    import sap_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       run,
    input  logic       halt_req,
    input  logic       hlt,
    output tstate_e    state,
    output logic [5:0] t_state
);
    tstate_e state_n;
    logic    halt_pend;
    always_comb begin
        state_n = state;
        if (run && state != HALTED)
            state_n = ((state == T4 && hlt) || (state == T6 && (halt_pend || halt_req))) ? HALTED :
                      state == T6 ? T1 : tstate_e'(state + 3'd1);
    end
    // A request is held until the ring actually enters HALTED.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= T1;
            halt_pend <= 1'b0;
        end else begin
            state     <= state_n;
            halt_pend <= (halt_pend || halt_req) && state_n != HALTED;
        end
    end
    assign t_state = state == HALTED ? 6'd0 : 6'b1 << state;
endmodule

// File: rtl/sap_controller.sv
// sap_controller: SAP-1 sequencer decoding the opcode into the 13-bit control word.
// Define SAP_CNTRL_JMP_EN to enable JMP (0011) and the Lp control bit.
module sap_controller
    import sap_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       run,
    input  logic       halt_req,
    input  logic [3:0] opcode,
    output logic [12:0] ctrl,
    output logic [5:0] t_state,
    output logic       instr_done,
    output logic       halted
);
    tstate_e    state;
    logic [3:0] op_q;
    logic [3:0] op;
    ctrl_t      c;
    sap_ring_counter u_ring (
        .CLK(CLK),
        .RESET(RESET),
        .run(run),
        .halt_req(halt_req),
        .hlt(opcode == OP_HLT),
        .state(state),
        .t_state(t_state)
    );
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) op_q <= '0;
        else if (run && state == T4) op_q <= opcode;
    end
    // T4 decodes the live IR nibble; later states use the copy taken on the T4 edge.
    assign op = state == T4 ? opcode : op_q;
    always_comb begin
        c = '0;
        case (state)
            T1: c = cw(EP) | cw(LM);
            T2: c = cw(CP);
            T3: c = cw(CE) | cw(LI);
            T4: case (op)
                OP_LDA, OP_ADD, OP_SUB: c = cw(EI) | cw(LM);
                OP_OUT: c = cw(EA) | cw(LO);
`ifdef SAP_CNTRL_JMP_EN
                OP_JMP: c = cw(EI) | cw(LP);
`endif
                default: c = '0;
            endcase
            T5: case (op)
                OP_LDA: c = cw(CE) | cw(LA);
                OP_ADD, OP_SUB: c = cw(CE) | cw(LB);
                default: c = '0;
            endcase
            T6: case (op)
                OP_ADD: c = cw(EU) | cw(LA);
                OP_SUB: c = cw(EU) | cw(LA) | cw(SU);
                default: c = '0;
            endcase
            default: c = '0;
        endcase
    end
    assign ctrl       = (run && !RESET) ? c : '0;
    assign instr_done = run && state == T6;
    assign halted     = state == HALTED;
endmodule

// File: tb/tb_sap_controller.sv
// tb_sap_controller: vector table, hand-written halt/reset sequences and a randomized run
// checked against an instruction-step reference model.
module tb_sap_controller;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        run = 1'b0;
    logic        halt_req = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic [12:0] ctrl;
    logic [5:0]  t_state;
    logic        instr_done;
    logic        halted;
    logic [20:0] obs;
    int total = 0;
    int passed = 0;
    int ms;
    logic mh, mp;
    logic [3:0] mq;

    typedef struct {
        logic        r;
        logic        h;
        logic [3:0]  op;
        logic [12:0] c;
        logic [5:0]  t;
        logic        d;
        logic        hl;
    } vec_t;
    vec_t vq[$];

`ifdef SAP_CNTRL_JMP_EN
    localparam logic [12:0] JMP4 = 13'h1020;
`else
    localparam logic [12:0] JMP4 = 13'h000;
`endif

    sap_controller dut (
        .CLK(CLK),
        .RESET(RESET),
        .run(run),
        .halt_req(halt_req),
        .opcode(opcode),
        .ctrl(ctrl),
        .t_state(t_state),
        .instr_done(instr_done),
        .halted(halted)
    );

    always #5 CLK = ~CLK;
    assign obs = {ctrl, t_state, instr_done, halted};

    task automatic chk(input string name, input logic [20:0] act, input logic [20:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got ctrl/t/done/halted=%h expected %h", name, act, exp);
    endtask

    task automatic apply(input string name, input logic r, input logic h, input logic [3:0] op,
                         input logic [20:0] e);
        run = r;
        halt_req = h;
        opcode = op;
        #1;
        chk(name, obs, e);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Called in the low phase of the clock; RESET is asserted and released before the next rise.
    task automatic do_reset();
        RESET = 1'b1;
        #1;
        chk("reset_state", obs, {13'h000, 6'h01, 1'b0, 1'b0});
        #1;
        RESET = 1'b0;
        ms = 0;
        mh = 1'b0;
        mp = 1'b0;
        mq = 4'h0;
    endtask

    task automatic add_instr(input logic [3:0] op, input logic [12:0] c4, input logic [12:0] c5,
                             input logic [12:0] c6);
        logic [12:0] w[6];
        logic [5:0] t;
        w = '{13'h006, 13'h001, 13'h018, c4, c5, c6};
        for (int i = 0; i < 6; i++) begin
            t = 6'b1 << i;
            vq.push_back(vec_t'{1'b1, 1'b0, op, w[i], t, i == 5, 1'b0});
        end
    endtask

    function automatic logic [12:0] mword(input logic [3:0] op, input int s);
        logic [12:0] w[6];
        w = '{13'h006, 13'h001, 13'h018, 13'h000, 13'h000, 13'h000};
        case (op)
            4'h0: begin w[3] = 13'h024; w[4] = 13'h048; end
            4'h1: begin w[3] = 13'h024; w[4] = 13'h408; w[5] = 13'h240; end
            4'h2: begin w[3] = 13'h024; w[4] = 13'h408; w[5] = 13'h340; end
            4'h3: w[3] = JMP4;
            4'hE: w[3] = 13'h880;
            default: ;
        endcase
        return w[s];
    endfunction

    initial begin
        logic r, h;
        logic [3:0] op, eop;
        logic [12:0] ec;
        logic [5:0] et;
        logic ed;
        add_instr(4'h0, 13'h024, 13'h048, 13'h000);
        add_instr(4'h1, 13'h024, 13'h408, 13'h240);
        add_instr(4'h2, 13'h024, 13'h408, 13'h340);
        add_instr(4'hE, 13'h880, 13'h000, 13'h000);
        add_instr(4'h3, JMP4, 13'h000, 13'h000);
        vq.push_back(vec_t'{1'b1, 1'b0, 4'h0, 13'h006, 6'h01, 1'b0, 1'b0});
        for (int i = 0; i < 3; i++)
            vq.push_back(vec_t'{1'b0, 1'b0, 4'h0, 13'h000, 6'h02, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b1, 1'b0, 4'h0, 13'h001, 6'h02, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b1, 1'b0, 4'h0, 13'h018, 6'h04, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b1, 1'b0, 4'h0, 13'h024, 6'h08, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b1, 1'b0, 4'h0, 13'h048, 6'h10, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b1, 1'b0, 4'h0, 13'h000, 6'h20, 1'b1, 1'b0});

        @(negedge CLK);
        do_reset();
        foreach (vq[i])
            apply($sformatf("vec%0d", i), vq[i].r, vq[i].h, vq[i].op,
                  {vq[i].c, vq[i].t, vq[i].d, vq[i].hl});

        // HLT: stop after T4 and stay halted until reset
        do_reset();
        apply("hlt_t1", 1, 0, 4'hF, {13'h006, 6'h01, 2'b00});
        apply("hlt_t2", 1, 0, 4'hF, {13'h001, 6'h02, 2'b00});
        apply("hlt_t3", 1, 0, 4'hF, {13'h018, 6'h04, 2'b00});
        apply("hlt_t4", 1, 0, 4'hF, {13'h000, 6'h08, 2'b00});
        repeat (20) apply("hlt_hold", 1, 0, 4'h0, {13'h000, 6'h00, 2'b01});
        do_reset();
        apply("post_hlt_fetch", 1, 0, 4'h0, {13'h006, 6'h01, 2'b00});

        // halt_req pulsed in ADD T3 lets ADD finish, then halts without a fetch
        do_reset();
        apply("hreq_t1", 1, 0, 4'h1, {13'h006, 6'h01, 2'b00});
        apply("hreq_t2", 1, 0, 4'h1, {13'h001, 6'h02, 2'b00});
        apply("hreq_t3", 1, 1, 4'h1, {13'h018, 6'h04, 2'b00});
        apply("hreq_t4", 1, 0, 4'h1, {13'h024, 6'h08, 2'b00});
        apply("hreq_t5", 1, 0, 4'h1, {13'h408, 6'h10, 2'b00});
        apply("hreq_t6", 1, 0, 4'h1, {13'h240, 6'h20, 2'b10});
        repeat (3) apply("hreq_halted", 1, 0, 4'h0, {13'h000, 6'h00, 2'b01});

        // asynchronous reset in the middle of ADD T5
        do_reset();
        apply("ar_t1", 1, 0, 4'h1, {13'h006, 6'h01, 2'b00});
        apply("ar_t2", 1, 0, 4'h1, {13'h001, 6'h02, 2'b00});
        apply("ar_t3", 1, 0, 4'h1, {13'h018, 6'h04, 2'b00});
        apply("ar_t4", 1, 0, 4'h1, {13'h024, 6'h08, 2'b00});
        #1;
        chk("ar_t5", obs, {13'h408, 6'h10, 2'b00});
        #1;
        RESET = 1'b1;
        #1;
        chk("ar_async", obs, {13'h000, 6'h01, 2'b00});
        RESET = 1'b0;
        apply("ar_refetch", 1, 0, 4'h0, {13'h006, 6'h01, 2'b00});

        // randomized run against the instruction-step model
        @(negedge CLK);
        do_reset();
        repeat (600) begin
            if ((mh && $urandom_range(0, 4) == 0) || $urandom_range(0, 99) == 0) do_reset();
            r = $urandom_range(0, 7) != 0;
            h = $urandom_range(0, 24) == 0;
            op = 4'($urandom_range(0, 15));
            eop = ms == 3 ? op : mq;
            ec = (mh || !r) ? 13'h000 : mword(eop, ms);
            et = mh ? 6'h00 : 6'b1 << ms;
            ed = !mh && r && ms == 5;
            apply("random", r, h, op, {ec, et, ed, mh});
            if (!mh && r) begin
                if (ms == 3 && op == 4'hF) mh = 1'b1;
                else if (ms == 5 && (mp || h)) mh = 1'b1;
                else begin
                    if (ms == 3) mq = op;
                    ms = (ms + 1) % 6;
                end
            end
            mp = (mp || h) && !mh;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
